// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that applies masked SET/CLEAR/TOGGLE/READ
// commands from two requesters to a shared JK flip-flop bank.
module jk_bank_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_mask,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_mask,
  output logic             req1_ready,
  output logic             jk_en,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  input  logic [WIDTH-1:0] q_in,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] q_out,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK
  } state_t;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] qpre_q, qpre_d;
  logic             en_q, en_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             done_q, done_d;
  logic             did_q, did_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic             err_q, err_d;

  logic             gnt_any;
  logic             gnt_id;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;
  logic [WIDTH-1:0] expected;

  // last_q holds the requester served most recently; ties go to the other
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) gnt_id = ~last_q;
    else                          gnt_id = req1_valid;
    sel_op   = gnt_id ? req1_op   : req0_op;
    sel_mask = gnt_id ? req1_mask : req0_mask;
  end

  assign req0_ready = (state_q == IDLE) & gnt_any & ~gnt_id;
  assign req1_ready = (state_q == IDLE) & gnt_any &  gnt_id;

  always_comb begin
    unique case (op_q)
      OP_SET:  expected = qpre_q | mask_q;
      OP_CLR:  expected = qpre_q & ~mask_q;
      OP_TOG:  expected = qpre_q ^ mask_q;
      default: expected = qpre_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    op_d    = op_q;
    mask_d  = mask_q;
    id_d    = id_q;
    qpre_d  = qpre_q;
    en_d    = 1'b0;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    did_d   = did_q;
    qout_d  = qout_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d = APPLY;
          last_d  = gnt_id;
          op_d    = sel_op;
          mask_d  = sel_mask;
          id_d    = gnt_id;
          qpre_d  = q_in;
          unique case (sel_op)
            OP_SET: begin
              en_d = 1'b1;
              j_d  = sel_mask;
            end
            OP_CLR: begin
              en_d = 1'b1;
              k_d  = sel_mask;
            end
            OP_TOG: begin
              en_d = 1'b1;
              j_d  = sel_mask;
              k_d  = sel_mask;
            end
            default: ;
          endcase
        end
      end
      APPLY: state_d = CHECK;
      CHECK: begin
        state_d = IDLE;
        done_d  = 1'b1;
        did_d   = id_q;
        qout_d  = q_in;
        err_d   = (q_in != expected);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      op_q    <= OP_READ;
      mask_q  <= '0;
      id_q    <= 1'b0;
      qpre_q  <= '0;
      en_q    <= 1'b0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      did_q   <= 1'b0;
      qout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
      qpre_q  <= qpre_d;
      en_q    <= en_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      did_q   <= did_d;
      qout_q  <= qout_d;
      err_q   <= err_d;
    end
  end

  assign jk_en   = en_q;
  assign jk_j    = j_q;
  assign jk_k    = k_q;
  assign done    = done_q;
  assign done_id = did_q;
  assign q_out   = qout_q;
  assign err     = err_q;

endmodule
